multicycle_ctrl: RTL and testbench

//  Control FSM for the multicycle RV32I datapath; generational successor to the single-cycle main decoder.

---
 rtl/riscv_ctrl_pkg.sv | 55 +++++
 rtl/mc_opdec.sv | 59 +++++
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes
// and the select codes driven onto the datapath muxes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JALRADR,
    S_JAL,
    S_LUI,
    S_AUIPC
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_opdec.sv
// Opcode decoder: picks the state that follows DECODE, the immediate format,
// and whether the opcode is legal for this configuration.
module mc_opdec
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_UTYPE = 1'b1
) (
  input  logic [6:0] op,
  output state_t     decode_next,
  output logic [2:0] imm_src,
  output logic       is_store,
  output logic       legal
);

  always_comb begin
    decode_next = S_FETCH;
    imm_src     = IMM_I;
    is_store    = 1'b0;
    legal       = 1'b1;
    case (op)
      OP_LW:   decode_next = S_MEMADR;
      OP_SW: begin
        decode_next = S_MEMADR;
        imm_src     = IMM_S;
        is_store    = 1'b1;
      end
      OP_R:    decode_next = S_EXECUTER;
      OP_IALU: decode_next = S_EXECUTEI;
      OP_BEQ: begin
        decode_next = S_BEQ;
        imm_src     = IMM_B;
      end
      OP_JAL: begin
        decode_next = S_JAL;
        imm_src     = IMM_J;
      end
      OP_JALR: decode_next = S_JALRADR;
      // U-type opcodes fall back to the illegal path when the feature is off
      OP_LUI: begin
        if (ENABLE_UTYPE) begin
          decode_next = S_LUI;
          imm_src     = IMM_U;
        end else begin
          legal = 1'b0;
        end
      end
      OP_AUIPC: begin
        if (ENABLE_UTYPE) begin
          decode_next = S_AUIPC;
          imm_src     = IMM_U;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences each instruction through its states,
// drives the datapath selects/enables, handshakes with memory, counts retires.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_UTYPE  = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             reg_write,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  state_t state, next;
  state_t decode_next;
  logic   is_store, legal, mem_done, retire;
  logic   pc_update, branch, req_raw, mwr_raw, irw_raw, rwr_raw, ill_raw;

  mc_opdec #(.ENABLE_UTYPE(ENABLE_UTYPE)) u_opdec (
    .op          (op),
    .decode_next (decode_next),
    .imm_src     (imm_src),
    .is_store    (is_store),
    .legal       (legal)
  );

  assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_FETCH:    if (mem_done) next = S_DECODE;
      S_DECODE:   next = decode_next;
      S_MEMADR:   next = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_done) next = S_MEMWB;
      S_MEMWRITE: if (mem_done) next = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC, S_JAL: next = S_ALUWB;
      S_JALRADR:  next = S_JAL;
      S_MEMWB, S_ALUWB, S_BEQ: next = S_FETCH;
      default:    next = S_FETCH;
    endcase
  end

  // Moore selects per state; FETCH's writes wait for the memory to answer
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    req_raw    = 1'b0;
    mwr_raw    = 1'b0;
    irw_raw    = 1'b0;
    rwr_raw    = 1'b0;
    ill_raw    = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        req_raw    = 1'b1;
        irw_raw    = mem_done;
        pc_update  = mem_done;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        ill_raw   = ~legal;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        req_raw = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        rwr_raw    = 1'b1;
      end
      S_MEMWRITE: begin
        req_raw = 1'b1;
        adr_src = 1'b1;
        mwr_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    rwr_raw = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JALRADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
  end

  // Enables are masked by reset so an aborted instruction never writes
  assign mem_req   = reset_n & req_raw;
  assign mem_write = reset_n & mwr_raw;
  assign ir_write  = reset_n & irw_raw;
  assign reg_write = reset_n & rwr_raw;
  assign illegal_o = reset_n & ill_raw;
  assign pc_write  = reset_n & (pc_update | (branch & zero));

  assign retire = (next == S_FETCH) &&
                  (state == S_MEMWB || state == S_MEMWRITE ||
                   state == S_ALUWB || state == S_BEQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    instret_o <= '0;
    else if (retire) instret_o <= instret_o + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words are
// queued with their stimulus and compared as the FSM steps through them.
module tb_multicycle_ctrl;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7,
                 AWB = 8, BQ = 9, JR = 10, JL = 11, LU = 12, AU = 13;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IA = 7'b0010011, BE = 7'b1100011, JA = 7'b1101111,
                         JRO = 7'b1100111, LUO = 7'b0110111, AUO = 7'b0010111;

  typedef struct packed {
    logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, ill;
    logic [1:0] res, a, b, aluop;
    logic [2:0] imm;
  } ctl_t;

  typedef struct {
    int         k;
    ctl_t       exp;
    logic       rdy;
    logic [6:0] op;
    logic       z;
    string      name;
  } rec_t;

  logic clk = 1'b0, reset_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [6:0] op = 7'b0;
  logic        mem_req_w [3], pc_write_w [3], adr_src_w [3], mem_write_w [3];
  logic        ir_write_w [3], reg_write_w [3], illegal_w [3];
  logic [1:0]  res_w [3], a_w [3], b_w [3], aluop_w [3];
  logic [2:0]  imm_w [3];
  logic [31:0] instret_w [3];

  int compared = 0, mismatched = 0;
  rec_t sb[$];

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: single-cycle memory; 2: U-type disabled
  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .ENABLE_UTYPE(1'b1), .CNT_W(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_w[0]), .pc_write(pc_write_w[0]), .adr_src(adr_src_w[0]),
    .mem_write(mem_write_w[0]), .ir_write(ir_write_w[0]), .result_src(res_w[0]),
    .alu_src_a(a_w[0]), .alu_src_b(b_w[0]), .alu_op(aluop_w[0]), .imm_src(imm_w[0]),
    .reg_write(reg_write_w[0]), .illegal_o(illegal_w[0]), .instret_o(instret_w[0]));

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .ENABLE_UTYPE(1'b1), .CNT_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_w[1]), .pc_write(pc_write_w[1]), .adr_src(adr_src_w[1]),
    .mem_write(mem_write_w[1]), .ir_write(ir_write_w[1]), .result_src(res_w[1]),
    .alu_src_a(a_w[1]), .alu_src_b(b_w[1]), .alu_op(aluop_w[1]), .imm_src(imm_w[1]),
    .reg_write(reg_write_w[1]), .illegal_o(illegal_w[1]), .instret_o(instret_w[1]));

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .ENABLE_UTYPE(1'b0), .CNT_W(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_w[2]), .pc_write(pc_write_w[2]), .adr_src(adr_src_w[2]),
    .mem_write(mem_write_w[2]), .ir_write(ir_write_w[2]), .result_src(res_w[2]),
    .alu_src_a(a_w[2]), .alu_src_b(b_w[2]), .alu_op(aluop_w[2]), .imm_src(imm_w[2]),
    .reg_write(reg_write_w[2]), .illegal_o(illegal_w[2]), .instret_o(instret_w[2]));

  function automatic ctl_t outs(input int k);
    ctl_t c;
    c = '{mem_req_w[k], pc_write_w[k], adr_src_w[k], mem_write_w[k], ir_write_w[k],
          reg_write_w[k], illegal_w[k], res_w[k], a_w[k], b_w[k], aluop_w[k], imm_w[k]};
    return c;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o, input logic utype);
    case (o)
      SW:       return 3'b001;
      BE:       return 3'b010;
      JA:       return 3'b011;
      LUO, AUO: return utype ? 3'b100 : 3'b000;
      default:  return 3'b000;
    endcase
  endfunction

  // Control word each state should present, straight from the state table
  function automatic ctl_t exps(input int s, input logic rdy, input logic z,
                                input logic [2:0] imm, input logic ill);
    ctl_t c;
    c = '0;
    c.imm = imm;
    case (s)
      F:   begin c.mem_req = 1; c.ir_write = rdy; c.pc_write = rdy; c.b = 2'b10; c.res = 2'b10; end
      D:   begin c.a = 2'b01; c.b = 2'b01; c.ill = ill; end
      MA:  begin c.a = 2'b10; c.b = 2'b01; end
      MR:  begin c.mem_req = 1; c.adr_src = 1; end
      MWB: begin c.res = 2'b01; c.reg_write = 1; end
      MW:  begin c.mem_req = 1; c.adr_src = 1; c.mem_write = 1; end
      ER:  begin c.a = 2'b10; c.aluop = 2'b10; end
      EI:  begin c.a = 2'b10; c.b = 2'b01; c.aluop = 2'b10; end
      AWB: c.reg_write = 1;
      BQ:  begin c.a = 2'b10; c.aluop = 2'b01; c.pc_write = z; end
      JR:  begin c.a = 2'b10; c.b = 2'b01; end
      JL:  begin c.a = 2'b01; c.b = 2'b10; c.pc_write = 1; end
      LU:  begin c.a = 2'b11; c.b = 2'b01; end
      AU:  begin c.a = 2'b01; c.b = 2'b01; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(input int k, input int s, input logic rdy, input logic [6:0] o,
                      input logic z, input string name, input logic ill = 1'b0);
    rec_t r;
    r.k = k; r.rdy = rdy; r.op = o; r.z = z; r.name = name;
    r.exp = exps(s, (k == 1) ? 1'b1 : rdy, z, imm_of(o, k != 2), ill);
    sb.push_back(r);
  endtask

  task automatic applyStimulus();
    rec_t r;
    ctl_t got;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(negedge clk);
      mem_ready = r.rdy; op = r.op; zero = r.z;
      #1;
      got = outs(r.k);
      compared++;
      if (got !== r.exp) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", r.name, got, r.exp);
      end
    end
  endtask

  task automatic checkOutput(input int k, input logic [31:0] exp, input string name);
    @(posedge clk);
    #1;
    compared++;
    if (instret_w[k] !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: instret got %0d expected %0d", name, instret_w[k], exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    ctl_t exp;
    mem_ready = 1'b1; op = LW;
    @(negedge clk);
    #1;
    compared++;
    if ({mem_req_w[0], pc_write_w[0], mem_write_w[0], ir_write_w[0], reg_write_w[0], illegal_w[0]} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_enables: got %b expected 000000",
               {mem_req_w[0], pc_write_w[0], mem_write_w[0], ir_write_w[0], reg_write_w[0], illegal_w[0]});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    exp = exps(F, 1'b1, 1'b0, 3'b000, 1'b0);
    compared++;
    if (outs(0) !== exp || instret_w[0] !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_release: got %h/%0d expected %h/0", outs(0), instret_w[0], exp);
    end
  endtask

  task automatic test_lw();
    do_reset();
    push(0, F, 0, LW, 0, "lw_fetch_w1"); push(0, F, 0, LW, 0, "lw_fetch_w2");
    push(0, F, 1, LW, 0, "lw_fetch");    push(0, D, 1, LW, 0, "lw_decode");
    push(0, MA, 1, LW, 0, "lw_memadr");  push(0, MR, 0, LW, 0, "lw_read_w1");
    push(0, MR, 0, LW, 0, "lw_read_w2"); push(0, MR, 1, LW, 0, "lw_read");
    push(0, MWB, 1, LW, 0, "lw_memwb");  push(0, F, 0, LW, 0, "lw_refetch");
    applyStimulus();
    checkOutput(0, 32'd1, "lw_instret");
  endtask

  task automatic test_sw_single_cycle();
    do_reset();
    push(1, F, 0, SW, 0, "sw_fetch");  push(1, D, 0, SW, 0, "sw_decode");
    push(1, MA, 0, SW, 0, "sw_memadr"); push(1, MW, 0, SW, 0, "sw_memwrite");
    push(1, F, 0, SW, 0, "sw_refetch");
    applyStimulus();
    checkOutput(1, 32'd1, "sw_instret");
  endtask

  task automatic test_beq();
    do_reset();
    push(0, F, 1, BE, 1, "beq1_fetch"); push(0, D, 1, BE, 1, "beq1_decode");
    push(0, BQ, 1, BE, 1, "beq_taken");
    push(0, F, 1, BE, 0, "beq0_fetch"); push(0, D, 1, BE, 0, "beq0_decode");
    push(0, BQ, 1, BE, 0, "beq_not_taken");
    applyStimulus();
    checkOutput(0, 32'd2, "beq_instret");
  endtask

  task automatic test_jalr();
    do_reset();
    push(0, F, 1, JRO, 0, "jalr_fetch");  push(0, D, 1, JRO, 0, "jalr_decode");
    push(0, JR, 1, JRO, 0, "jalr_adr");   push(0, JL, 1, JRO, 0, "jalr_jal");
    push(0, AWB, 1, JRO, 0, "jalr_aluwb");
    applyStimulus();
    checkOutput(0, 32'd1, "jalr_instret");
  endtask

  task automatic test_utype();
    do_reset();
    push(2, F, 1, LUO, 0, "lui_off_fetch"); push(2, D, 1, LUO, 0, "lui_off_illegal", 1'b1);
    push(2, F, 0, LUO, 0, "lui_off_refetch");
    applyStimulus();
    checkOutput(2, 32'd0, "lui_off_instret");
    do_reset();
    push(0, F, 1, LUO, 0, "lui_fetch"); push(0, D, 1, LUO, 0, "lui_decode");
    push(0, LU, 1, LUO, 0, "lui_exec"); push(0, AWB, 1, LUO, 0, "lui_aluwb");
    applyStimulus();
    checkOutput(0, 32'd1, "lui_instret");
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(0, F, 1, RT, 0, "r_fetch");   push(0, D, 1, RT, 0, "r_decode");
    push(0, ER, 1, RT, 0, "r_exec");   push(0, AWB, 1, RT, 0, "r_aluwb");
    push(0, F, 1, IA, 0, "i_fetch");   push(0, D, 1, IA, 0, "i_decode");
    push(0, EI, 1, IA, 0, "i_exec");   push(0, AWB, 1, IA, 0, "i_aluwb");
    push(0, F, 1, AUO, 0, "au_fetch"); push(0, D, 1, AUO, 0, "au_decode");
    push(0, AU, 1, AUO, 0, "au_exec"); push(0, AWB, 1, AUO, 0, "au_aluwb");
    push(0, F, 1, JA, 0, "jal_fetch"); push(0, D, 1, JA, 0, "jal_decode");
    push(0, JL, 1, JA, 0, "jal_jal");  push(0, AWB, 1, JA, 0, "jal_aluwb");
    applyStimulus();
    checkOutput(0, 32'd4, "b2b_instret");
  endtask

  task automatic test_reset_mid();
    ctl_t exp;
    do_reset();
    push(0, F, 1, BE, 0, "pre_fetch"); push(0, D, 1, BE, 0, "pre_decode");
    push(0, BQ, 1, BE, 0, "pre_beq");
    applyStimulus();
    checkOutput(0, 32'd1, "pre_instret");
    push(0, F, 1, SW, 0, "sw_hs_fetch"); push(0, D, 1, SW, 0, "sw_hs_decode");
    push(0, MA, 1, SW, 0, "sw_hs_memadr"); push(0, MW, 0, SW, 0, "sw_hs_wait");
    push(0, MW, 0, SW, 0, "sw_hs_hold");
    applyStimulus();
    #1 reset_n = 1'b0;
    #1;
    compared++;
    if (mem_write_w[0] !== 1'b0 || mem_req_w[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_write: got wr=%b req=%b expected 0/0", mem_write_w[0], mem_req_w[0]);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    exp = exps(F, 1'b0, 1'b0, 3'b001, 1'b0);
    compared++;
    if (outs(0) !== exp || instret_w[0] !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL abort_release: got %h/%0d expected %h/0", outs(0), instret_w[0], exp);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_single_cycle();
    test_beq();
    test_jalr();
    test_utype();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
